// File: rtl/if_fetch_queue.sv
// Decoupled IF stage: PC generator, in-order multi-outstanding fetch on the sram-like
// inst bus, and a small instruction queue feeding ID. Flushes cancel in-flight responses by counting.
module if_fetch_queue #(
    parameter int          IQ_DEPTH  = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'hbfc00000,
    parameter logic [4:0]  EXC_ADEL  = 5'h04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_flush_valid,
    input  logic [31:0] i_flush_pc,
    input  logic        i_ds_allowin,
    output logic        o_fs_to_ds_valid,
    output logic [69:0] o_fs_to_ds_bus,
    output logic        o_inst_sram_req,
    output logic        o_inst_sram_wr,
    output logic [1:0]  o_inst_sram_size,
    output logic [3:0]  o_inst_sram_wstrb,
    output logic [31:0] o_inst_sram_addr,
    output logic [31:0] o_inst_sram_wdata,
    input  logic        i_inst_sram_addr_ok,
    input  logic        i_inst_sram_data_ok,
    input  logic [31:0] i_inst_sram_rdata
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(IQ_DEPTH) + 1;
    localparam int QW = $clog2(IQ_DEPTH);
    localparam int FW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int SW = CW + 2;

    logic [31:0]   r_pc;
    logic [OW-1:0] r_outst;
    logic [OW-1:0] r_cancel;
    logic          r_halt;

    logic [69:0]   r_q [IQ_DEPTH];
    logic [QW-1:0] r_q_wr;
    logic [QW-1:0] r_q_rd;
    logic [CW-1:0] r_count;

    logic [31:0]   r_fpc [MAX_OUTST];
    logic [FW-1:0] r_f_wr;
    logic [FW-1:0] r_f_rd;

    logic          w_aligned;
    logic [SW-1:0] w_occ;
    logic          w_req;
    logic          w_accept;
    logic          w_data_push;
    logic          w_exc_push;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [69:0]   w_push_entry;
    logic [FW-1:0] w_f_wr_next;
    logic [FW-1:0] w_f_rd_next;

    // Cancelled responses still occupy a reserved slot until they return.
    assign w_aligned = (r_pc[1:0] == 2'b00);
    assign w_occ     = SW'(r_outst) + SW'(r_cancel) + SW'(r_count);
    assign w_req     = !reset && !i_flush_valid && !r_halt && w_aligned
                       && (r_outst < OW'(MAX_OUTST)) && (w_occ < SW'(IQ_DEPTH));
    assign w_accept  = w_req && i_inst_sram_addr_ok;

    assign w_data_push = i_inst_sram_data_ok && (r_cancel == '0) && !i_flush_valid;
    assign w_exc_push  = !i_flush_valid && !w_aligned && !r_halt && (r_cancel == '0)
                         && (r_count < CW'(IQ_DEPTH)) && !w_data_push;
    assign w_push      = w_data_push || w_exc_push;
    assign w_valid     = !reset && (r_count != '0);
    assign w_pop       = w_valid && i_ds_allowin;

    assign w_push_entry = w_data_push ? {1'b0, 5'b0, i_inst_sram_rdata, r_fpc[r_f_rd]}
                                      : {1'b1, EXC_ADEL, 32'b0, r_pc};

    assign w_f_wr_next = (r_f_wr == FW'(MAX_OUTST - 1)) ? '0 : r_f_wr + FW'(1);
    assign w_f_rd_next = (r_f_rd == FW'(MAX_OUTST - 1)) ? '0 : r_f_rd + FW'(1);

    assign o_inst_sram_req   = w_req;
    assign o_inst_sram_wr    = 1'b0;
    assign o_inst_sram_size  = 2'h2;
    assign o_inst_sram_wstrb = 4'h0;
    assign o_inst_sram_wdata = 32'h0;
    assign o_inst_sram_addr  = reset ? 32'h0 : r_pc;
    assign o_fs_to_ds_valid  = w_valid;
    assign o_fs_to_ds_bus    = w_valid ? r_q[r_q_rd] : 70'h0;

    // In-flight PC pointers keep running across a flush: the stale entries pop
    // with their cancelled responses, so later requests stay paired with their data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_halt   <= 1'b0;
            r_outst  <= '0;
            r_cancel <= '0;
            r_f_wr   <= '0;
            r_f_rd   <= '0;
            r_q_wr   <= '0;
            r_q_rd   <= '0;
            r_count  <= '0;
        end else begin
            if (i_flush_valid) begin
                r_pc   <= i_flush_pc;
                r_halt <= 1'b0;
            end else begin
                if (w_accept)
                    r_pc <= r_pc + 32'd4;
                if (w_exc_push)
                    r_halt <= 1'b1;
            end

            r_outst <= r_outst + OW'(w_accept) - OW'(i_inst_sram_data_ok);

            if (i_flush_valid)
                r_cancel <= r_cancel + r_outst - OW'(i_inst_sram_data_ok);
            else if (i_inst_sram_data_ok && (r_cancel != '0))
                r_cancel <= r_cancel - OW'(1);

            if (w_accept)
                r_f_wr <= w_f_wr_next;
            if (i_inst_sram_data_ok)
                r_f_rd <= w_f_rd_next;

            if (i_flush_valid) begin
                r_q_wr  <= '0;
                r_q_rd  <= '0;
                r_count <= '0;
            end else begin
                if (w_push)
                    r_q_wr <= r_q_wr + QW'(1);
                if (w_pop)
                    r_q_rd <= r_q_rd + QW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept)
            r_fpc[r_f_wr] <= r_pc;
        if (!reset && w_push)
            r_q[r_q_wr] <= w_push_entry;
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed cycle-by-cycle bench for if_fetch_queue: in-order fetch, outstanding limit,
// queue backpressure, flush cancellation, misaligned-PC exception and mid-run reset.
module tb_if_fetch_queue;

    logic        clk;
    logic        reset;
    logic        flushValid;
    logic [31:0] flushPc;
    logic        dsAllowin;
    logic        fsToDsValid;
    logic [69:0] fsToDsBus;
    logic        sramReq;
    logic        sramWr;
    logic [1:0]  sramSize;
    logic [3:0]  sramWstrb;
    logic [31:0] sramAddr;
    logic [31:0] sramWdata;
    logic        addrOk;
    logic        dataOk;
    logic [31:0] rdata;

    int checkCount = 0;
    int failCount  = 0;

    if_fetch_queue dut (
        .clk                 (clk),
        .reset               (reset),
        .i_flush_valid       (flushValid),
        .i_flush_pc          (flushPc),
        .i_ds_allowin        (dsAllowin),
        .o_fs_to_ds_valid    (fsToDsValid),
        .o_fs_to_ds_bus      (fsToDsBus),
        .o_inst_sram_req     (sramReq),
        .o_inst_sram_wr      (sramWr),
        .o_inst_sram_size    (sramSize),
        .o_inst_sram_wstrb   (sramWstrb),
        .o_inst_sram_addr    (sramAddr),
        .o_inst_sram_wdata   (sramWdata),
        .i_inst_sram_addr_ok (addrOk),
        .i_inst_sram_data_ok (dataOk),
        .i_inst_sram_rdata   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [69:0] observed, input logic [69:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fv, input logic [31:0] fpc, input logic allow,
                                 input logic aok, input logic dok, input logic [31:0] rd);
        flushValid = fv;
        flushPc    = fpc;
        dsAllowin  = allow;
        addrOk     = aok;
        dataOk     = dok;
        rdata      = rd;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [69:0] makeEntry(input logic ex, input logic [4:0] code,
                                              input logic [31:0] inst, input logic [31:0] pc);
        return {ex, code, inst, pc};
    endfunction

    localparam logic [31:0] A0 = 32'hbfc00000;

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req", 70'(sramReq), 70'(0));
        checkOutput("rst_valid", 70'(fsToDsValid), 70'(0));
        checkOutput("rst_bus", fsToDsBus, 70'(0));
        checkOutput("rst_addr", 70'(sramAddr), 70'(0));
        checkOutput("rst_size", 70'(sramSize), 70'(2));
        checkOutput("rst_const", 70'({sramWr, sramWstrb, sramWdata}), 70'(0));

        // Streaming fetch until the queue fills
        reset = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t1_req0", 70'(sramReq), 70'(1));
        checkOutput("t1_addr0", 70'(sramAddr), 70'(A0));
        nextCycle();
        applyStimulus(0, 0, 0, 1, 1, 32'h11110000);
        checkOutput("t1_addr1", 70'(sramAddr), 70'(A0 + 4));
        checkOutput("t1_valid_lat", 70'(fsToDsValid), 70'(0));
        nextCycle();
        applyStimulus(0, 0, 0, 1, 1, 32'h11110004);
        checkOutput("t1_head0", fsToDsBus, makeEntry(0, 0, 32'h11110000, A0));
        checkOutput("t1_addr2", 70'({sramReq, sramAddr}), 70'({1'b1, A0 + 32'd8}));
        nextCycle();
        applyStimulus(0, 0, 0, 1, 1, 32'h11110008);
        checkOutput("t1_addr3", 70'({sramReq, sramAddr}), 70'({1'b1, A0 + 32'd12}));
        nextCycle();
        applyStimulus(0, 0, 0, 1, 1, 32'h1111000c);
        checkOutput("t3_req_full", 70'(sramReq), 70'(0));
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t3_req_held", 70'(sramReq), 70'(0));
        checkOutput("t3_pop0", fsToDsBus, makeEntry(0, 0, 32'h11110000, A0));
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t3_pop1", fsToDsBus, makeEntry(0, 0, 32'h11110004, A0 + 32'd4));
        checkOutput("t3_req_back", 70'({sramReq, sramAddr}), 70'({1'b1, A0 + 32'd16}));
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t3_pop2", fsToDsBus, makeEntry(0, 0, 32'h11110008, A0 + 32'd8));
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t3_pop3", fsToDsBus, makeEntry(0, 0, 32'h1111000c, A0 + 32'd12));
        nextCycle();

        // Outstanding limit with data withheld
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t3_empty", 70'(fsToDsValid), 70'(0));
        checkOutput("t2_acc0", 70'({sramReq, sramAddr}), 70'({1'b1, A0 + 32'd16}));
        nextCycle();
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t2_acc1", 70'({sramReq, sramAddr}), 70'({1'b1, A0 + 32'd20}));
        nextCycle();
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t2_limit", 70'(sramReq), 70'(0));
        nextCycle();
        applyStimulus(0, 0, 0, 1, 1, 32'h22220010);
        checkOutput("t2_limit_dok", 70'(sramReq), 70'(0));
        nextCycle();
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t2_req_again", 70'({sramReq, sramAddr}), 70'({1'b1, A0 + 32'd24}));
        checkOutput("t2_head", fsToDsBus, makeEntry(0, 0, 32'h22220010, A0 + 32'd16));
        nextCycle();

        // Flush with two requests in flight
        applyStimulus(1, 32'hbfc00380, 0, 1, 0, 0);
        checkOutput("t4_flush_req", 70'(sramReq), 70'(0));
        nextCycle();
        applyStimulus(0, 0, 0, 1, 1, 32'hdead0014);
        checkOutput("t4_cleared", 70'(fsToDsValid), 70'(0));
        checkOutput("t4_req_blk", 70'(sramReq), 70'(0));
        nextCycle();
        applyStimulus(0, 0, 0, 1, 1, 32'hdead0018);
        checkOutput("t4_drop1", 70'(fsToDsValid), 70'(0));
        checkOutput("t4_req_tgt", 70'({sramReq, sramAddr}), 70'({1'b1, 32'hbfc00380}));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 32'h33330380);
        checkOutput("t4_drop2", 70'(fsToDsValid), 70'(0));
        checkOutput("t4_req_next", 70'({sramReq, sramAddr}), 70'({1'b1, 32'hbfc00384}));
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t4_head", fsToDsBus, makeEntry(0, 0, 32'h33330380, 32'hbfc00380));
        nextCycle();

        // Flush coinciding with the only outstanding response
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t5_acc", 70'({fsToDsValid, sramReq, sramAddr}), 70'({2'b01, 32'hbfc00384}));
        nextCycle();
        applyStimulus(1, 32'hbfc00400, 0, 1, 1, 32'hdead0384);
        checkOutput("t5_flush_req", 70'(sramReq), 70'(0));
        nextCycle();
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t5_dropped", 70'(fsToDsValid), 70'(0));
        checkOutput("t5_req_tgt", 70'({sramReq, sramAddr}), 70'({1'b1, 32'hbfc00400}));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 32'h44440400);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t5_head", fsToDsBus, makeEntry(0, 0, 32'h44440400, 32'hbfc00400));
        nextCycle();

        // Misaligned redirect raises an exception entry and halts
        applyStimulus(1, 32'hbfc00002, 0, 0, 0, 0);
        checkOutput("t6_flush_req", 70'(sramReq), 70'(0));
        nextCycle();
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t6_no_req", 70'(sramReq), 70'(0));
        nextCycle();
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("t6_exc", fsToDsBus, makeEntry(1, 5'h04, 32'h0, 32'hbfc00002));
        checkOutput("t6_exc_noreq", 70'(sramReq), 70'(0));
        nextCycle();
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t6_halted", 70'({fsToDsValid, sramReq}), 70'(0));
        nextCycle();
        applyStimulus(1, 32'hbfc00380, 0, 1, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t6_resume", 70'({sramReq, sramAddr}), 70'({1'b1, 32'hbfc00380}));
        nextCycle();

        // Reset while a request is outstanding
        reset = 1'b1;
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("rst2_req", 70'({fsToDsValid, sramReq}), 70'(0));
        nextCycle();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("rst2_addr", 70'({sramReq, sramAddr}), 70'({1'b1, A0}));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 32'h55550000);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst2_head", fsToDsBus, makeEntry(0, 0, 32'h55550000, A0));

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
